// File: rtl/render_menu.sv
// render_menu: scaled 1-bpp title plus NUM_BTN stacked buttons with labels,
// mouse hover/press/release tracking and a one-cycle select pulse.
//
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   en                  screen active; low forces pixel=C_BG and FSM idle
//   h_cnt, v_cnt        current pixel position (pixel follows 3 clk later)
//   frame_start         one-cycle pulse per frame, drives the title blink
//   mouse_x/y, mouse_l  mouse position and left-button level
//   ttl_addr/ttl_bit    title ROM port (1-cycle read latency)
//   lbl_addr/lbl_bit    label ROM port (1-cycle read latency)
//   pixel               RGB444, registered
//   hover_idx           button under the mouse, NUM_BTN when none
//   sel_pulse/sel_idx   completed click and the button it landed on
module render_menu #(
    parameter int NUM_BTN   = 2,
    parameter int TTL_X     = 170,
    parameter int TTL_Y     = 150,
    parameter int TTL_W     = 60,
    parameter int TTL_H     = 20,
    parameter int TTL_S     = 5,
    parameter int LBL_W     = 100,
    parameter int LBL_H     = 20,
    parameter int LBL_S     = 2,
    parameter int BTN_X     = 200,
    parameter int BTN_Y     = 270,
    parameter int BTN_W     = 240,
    parameter int BTN_H     = 60,
    parameter int BTN_PITCH = 80,
    parameter int BLINK_FR  = 0,
    parameter logic [11:0] C_FG  = 12'hfff,
    parameter logic [11:0] C_BG  = 12'h000,
    parameter logic [11:0] C_BTN = 12'h521,
    parameter logic [11:0] C_HOV = 12'h632,
    parameter logic [11:0] C_PRS = 12'h743
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        frame_start,
    input  logic [9:0]  mouse_x,
    input  logic [9:0]  mouse_y,
    input  logic        mouse_l,
    output logic [10:0] ttl_addr,
    input  logic        ttl_bit,
    output logic [12:0] lbl_addr,
    input  logic        lbl_bit,
    output logic [11:0] pixel,
    output logic [2:0]  hover_idx,
    output logic        sel_pulse,
    output logic [2:0]  sel_idx
);

    localparam logic [2:0] NONE = 3'(NUM_BTN);

    // Label is centred inside its box.
    localparam int LBL_XO = (BTN_W - LBL_W * LBL_S) / 2;
    localparam int LBL_YO = (BTN_H - LBL_H * LBL_S) / 2;

    // Last value of the frame counter before it wraps.
    localparam int FR_LAST = (BLINK_FR > 0) ? (2 * BLINK_FR - 1) : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS,
        S_FIRE,
        S_ARMED
    } state_t;

    function automatic int f_by(input int k);
        return BTN_Y + k * BTN_PITCH;
    endfunction

    function automatic logic f_in_box(input int x, input int y, input int k);
        return (x >= BTN_X) && (x < BTN_X + BTN_W) &&
               (y >= f_by(k)) && (y < f_by(k) + BTN_H);
    endfunction

    function automatic logic f_in_lbl(input int x, input int y, input int k);
        return (x >= BTN_X + LBL_XO) &&
               (x < BTN_X + LBL_XO + LBL_W * LBL_S) &&
               (y >= f_by(k) + LBL_YO) &&
               (y < f_by(k) + LBL_YO + LBL_H * LBL_S);
    endfunction

    int w_h;
    int w_v;
    int w_mx;
    int w_my;

    assign w_h  = {22'd0, h_cnt};
    assign w_v  = {22'd0, v_cnt};
    assign w_mx = {22'd0, mouse_x};
    assign w_my = {22'd0, mouse_y};

    // ---------------- frame counter / blink ----------------
    logic [15:0] r_frm;
    logic        w_show;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frm <= 16'd0;
        end else if (frame_start) begin
            if (r_frm >= 16'(FR_LAST))
                r_frm <= 16'd0;
            else
                r_frm <= r_frm + 16'd1;
        end
    end

    assign w_show = (BLINK_FR == 0) || (r_frm < 16'(BLINK_FR));

    // ---------------- stage 1: regions and addresses ----------------
    logic        w_ttl_in;
    logic [10:0] w_ttl_addr;
    logic        w_lbl_in;
    logic [12:0] w_lbl_addr;
    logic        w_box_in;
    logic [2:0]  w_box_idx;

    always_comb begin
        w_ttl_in   = 1'b0;
        w_ttl_addr = 11'd0;
        w_lbl_in   = 1'b0;
        w_lbl_addr = 13'd0;
        w_box_in   = 1'b0;
        w_box_idx  = 3'd0;

        if ((w_h >= TTL_X) && (w_h < TTL_X + TTL_W * TTL_S) &&
            (w_v >= TTL_Y) && (w_v < TTL_Y + TTL_H * TTL_S)) begin
            w_ttl_in   = 1'b1;
            w_ttl_addr = 11'(((w_v - TTL_Y) / TTL_S) * TTL_W +
                             (w_h - TTL_X) / TTL_S);
        end

        // Walk downwards so the lowest index ends up winning.
        for (int k = NUM_BTN - 1; k >= 0; k--) begin
            if (f_in_box(w_h, w_v, k)) begin
                w_box_in  = 1'b1;
                w_box_idx = 3'(k);
            end
            if (f_in_lbl(w_h, w_v, k)) begin
                w_lbl_in   = 1'b1;
                w_lbl_addr = 13'(k * LBL_W * LBL_H +
                    ((w_v - f_by(k) - LBL_YO) / LBL_S) * LBL_W +
                    (w_h - BTN_X - LBL_XO) / LBL_S);
            end
        end
    end

    logic       r_ttl_f1;
    logic       r_lbl_f1;
    logic       r_box_f1;
    logic [2:0] r_box_idx1;
    logic       r_ttl_f2;
    logic       r_lbl_f2;
    logic       r_box_f2;
    logic [2:0] r_box_idx2;

    always_ff @(posedge clk) begin
        if (rst) begin
            ttl_addr   <= 11'd0;
            lbl_addr   <= 13'd0;
            r_ttl_f1   <= 1'b0;
            r_lbl_f1   <= 1'b0;
            r_box_f1   <= 1'b0;
            r_box_idx1 <= 3'd0;
            r_ttl_f2   <= 1'b0;
            r_lbl_f2   <= 1'b0;
            r_box_f2   <= 1'b0;
            r_box_idx2 <= 3'd0;
        end else begin
            ttl_addr   <= w_ttl_addr;
            lbl_addr   <= w_lbl_addr;
            // A hidden title simply never claims its pixels.
            r_ttl_f1   <= w_ttl_in & w_show;
            r_lbl_f1   <= w_lbl_in;
            r_box_f1   <= w_box_in;
            r_box_idx1 <= w_box_idx;
            // Stage 2: ROM data arrives, flags follow.
            r_ttl_f2   <= r_ttl_f1;
            r_lbl_f2   <= r_lbl_f1;
            r_box_f2   <= r_box_f1;
            r_box_idx2 <= r_box_idx1;
        end
    end

    // ---------------- hover ----------------
    logic [2:0] r_hover;
    logic [2:0] w_hover;

    always_comb begin
        w_hover = NONE;
        for (int k = NUM_BTN - 1; k >= 0; k--) begin
            if (f_in_box(w_mx, w_my, k))
                w_hover = 3'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_hover <= NONE;
        else
            r_hover <= w_hover;
    end

    assign hover_idx = r_hover;

    // ---------------- click FSM ----------------
    state_t     r_state;
    logic [2:0] r_p;
    logic       r_ml;
    logic       r_ml_d;
    logic       w_rise;

    assign w_rise = r_ml & ~r_ml_d;

    // The mouse level registers reset high so a button still held
    // through reset is never seen as a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_p       <= 3'd0;
            r_ml      <= 1'b1;
            r_ml_d    <= 1'b1;
            sel_pulse <= 1'b0;
            sel_idx   <= 3'd0;
        end else begin
            r_ml      <= mouse_l;
            r_ml_d    <= r_ml;
            sel_pulse <= 1'b0;
            if (!en) begin
                r_state <= S_IDLE;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_rise) begin
                            if (r_hover < NONE) begin
                                r_state <= S_PRESS;
                                r_p     <= r_hover;
                            end else begin
                                r_state <= S_ARMED;
                            end
                        end
                    end
                    S_PRESS: begin
                        if (!r_ml) begin
                            if (r_hover == r_p) begin
                                r_state   <= S_FIRE;
                                sel_pulse <= 1'b1;
                                sel_idx   <= r_p;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    S_FIRE: begin
                        r_state <= S_IDLE;
                    end
                    S_ARMED: begin
                        if (!r_ml)
                            r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // ---------------- stage 3: pixel ----------------
    logic [11:0] w_box_col;
    logic [11:0] w_pix;

    always_comb begin
        if ((r_state == S_PRESS) && (r_p == r_box_idx2))
            w_box_col = C_PRS;
        else if (r_hover == r_box_idx2)
            w_box_col = C_HOV;
        else
            w_box_col = C_BTN;

        if (r_ttl_f2 && ttl_bit)
            w_pix = C_FG;
        else if (r_lbl_f2 && lbl_bit)
            w_pix = C_FG;
        else if (r_box_f2)
            w_pix = w_box_col;
        else
            w_pix = C_BG;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pixel <= C_BG;
        else if (!en)
            pixel <= C_BG;
        else
            pixel <= w_pix;
    end

endmodule
